// File: rtl/csa_multiword_ctrl.sv
// Multi-byte add/subtract sequencer. One 8-bit conditional-sum adder is reused
// over NBYTES cycles, least-significant byte first, with the carry kept in a register.

module conditional_sum_adder (
    input  logic [7:0] inp1,
    input  logic [7:0] inp2,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);
    // sN/cN hold the group sums and carries for an assumed carry-in of 0 or 1.
    // Each level merges pairs of groups and doubles the group size.
    logic [7:0] s0_l0, s1_l0, c0_l0, c1_l0;
    logic [7:0] s0_l1, s1_l1;
    logic [3:0] c0_l1, c1_l1;
    logic [7:0] s0_l2, s1_l2;
    logic [1:0] c0_l2, c1_l2;
    logic [7:0] s0_l3, s1_l3;
    logic       c0_l3, c1_l3;

    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_bit
        assign s0_l0[gi] = inp1[gi] ^ inp2[gi];
        assign s1_l0[gi] = ~(inp1[gi] ^ inp2[gi]);
        assign c0_l0[gi] = inp1[gi] & inp2[gi];
        assign c1_l0[gi] = inp1[gi] | inp2[gi];
    end

    for (gi = 0; gi < 4; gi++) begin : g_l1
        assign s0_l1[2*gi]   = s0_l0[2*gi];
        assign s1_l1[2*gi]   = s1_l0[2*gi];
        assign s0_l1[2*gi+1] = c0_l0[2*gi] ? s1_l0[2*gi+1] : s0_l0[2*gi+1];
        assign s1_l1[2*gi+1] = c1_l0[2*gi] ? s1_l0[2*gi+1] : s0_l0[2*gi+1];
        assign c0_l1[gi]     = c0_l0[2*gi] ? c1_l0[2*gi+1] : c0_l0[2*gi+1];
        assign c1_l1[gi]     = c1_l0[2*gi] ? c1_l0[2*gi+1] : c0_l0[2*gi+1];
    end

    for (gi = 0; gi < 2; gi++) begin : g_l2
        assign s0_l2[4*gi+1:4*gi]   = s0_l1[4*gi+1:4*gi];
        assign s1_l2[4*gi+1:4*gi]   = s1_l1[4*gi+1:4*gi];
        assign s0_l2[4*gi+3:4*gi+2] = c0_l1[2*gi] ? s1_l1[4*gi+3:4*gi+2] : s0_l1[4*gi+3:4*gi+2];
        assign s1_l2[4*gi+3:4*gi+2] = c1_l1[2*gi] ? s1_l1[4*gi+3:4*gi+2] : s0_l1[4*gi+3:4*gi+2];
        assign c0_l2[gi]            = c0_l1[2*gi] ? c1_l1[2*gi+1] : c0_l1[2*gi+1];
        assign c1_l2[gi]            = c1_l1[2*gi] ? c1_l1[2*gi+1] : c0_l1[2*gi+1];
    end

    assign s0_l3[3:0] = s0_l2[3:0];
    assign s1_l3[3:0] = s1_l2[3:0];
    assign s0_l3[7:4] = c0_l2[0] ? s1_l2[7:4] : s0_l2[7:4];
    assign s1_l3[7:4] = c1_l2[0] ? s1_l2[7:4] : s0_l2[7:4];
    assign c0_l3      = c0_l2[0] ? c1_l2[1] : c0_l2[1];
    assign c1_l3      = c1_l2[0] ? c1_l2[1] : c0_l2[1];

    assign sum  = cin ? s1_l3 : s0_l3;
    assign cout = cin ? c1_l3 : c0_l3;
endmodule

module csa_multiword_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_valid,
    output logic                start_ready,
    input  logic [8*NBYTES-1:0] op_a,
    input  logic [8*NBYTES-1:0] op_b,
    input  logic                sub,
    input  logic                cin_ext,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [8*NBYTES-1:0] result,
    output logic                cout,
    output logic                ovf,
    output logic                busy
);
    localparam int W    = 8 * NBYTES;
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q;
    logic [IDXW-1:0] idx_q;
    logic            carry_q;
    logic [W-1:0]    a_q, b_q, result_q;
    logic            cout_q, ovf_q;

    logic [7:0]      a_byte, b_byte, add_sum;
    logic            add_cout;
    logic [W-1:0]    result_d;

    if (NBYTES == 1) begin : g_single
        assign a_byte = a_q;
        assign b_byte = b_q;
    end else begin : g_multi
        assign a_byte = a_q[{idx_q, 3'b000} +: 8];
        assign b_byte = b_q[{idx_q, 3'b000} +: 8];
    end

    conditional_sum_adder u_adder (
        .inp1 (a_byte),
        .inp2 (b_byte),
        .cin  (carry_q),
        .sum  (add_sum),
        .cout (add_cout)
    );

    genvar gi;
    for (gi = 0; gi < NBYTES; gi++) begin : g_res
        assign result_d[8*gi +: 8] = (idx_q == IDXW'(gi)) ? add_sum : result_q[8*gi +: 8];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_valid) begin
                        a_q      <= op_a;
                        b_q      <= op_b ^ {W{sub}};
                        carry_q  <= sub | cin_ext;
                        idx_q    <= '0;
                        result_q <= '0;
                        state_q  <= RUN;
                    end
                end
                RUN: begin
                    result_q <= result_d;
                    carry_q  <= add_cout;
                    idx_q    <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        // Operands agree in sign but the top byte's sum flips it.
                        cout_q  <= add_cout;
                        ovf_q   <= (a_q[W-1] == b_q[W-1]) && (add_sum[7] != a_q[W-1]);
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign start_ready = (state_q == IDLE);
    assign res_valid   = (state_q == DONE);
    assign busy        = (state_q != IDLE);
    assign result      = result_q;
    assign cout        = cout_q;
    assign ovf         = ovf_q;
endmodule
